// File: rtl/bf_weight_ctrl_if.sv
// -----------------------------------------------------------------------------
// bf_weight_ctrl_if
// Host-side bus of the beamformer weight controller: the valid/ready weight
// write port, the commit request, the LO frame tick and the commit status.
//   master : the host / register block (drives writes, commit_req, frame_tick)
//   slave  : bf_weight_ctrl (drives wr_ready and the commit status flags)
// Parameters: CH_AW channel address width, W_W weight width.
// -----------------------------------------------------------------------------
interface bf_weight_ctrl_if #(
  parameter int CH_AW = 3,
  parameter int W_W   = 5
);
  logic             wr_valid;
  logic             wr_ready;
  logic [CH_AW+1:0] wr_addr;
  logic [W_W-1:0]   wr_data;
  logic             commit_req;
  logic             frame_tick;
  logic             commit_done;
  logic             commit_err;
  logic             weights_valid;

  modport master (
    output wr_valid, wr_addr, wr_data, commit_req, frame_tick,
    input  wr_ready, commit_done, commit_err, weights_valid
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, commit_req, frame_tick,
    output wr_ready, commit_done, commit_err, weights_valid
  );
endinterface

// File: rtl/bf_weight_ctrl.sv
// -----------------------------------------------------------------------------
// bf_weight_ctrl
// Double-buffered weight store for the 8-channel, 2-beam beamformer. The host
// writes single 5-bit weights into a shadow bank; a commit request copies the
// whole shadow bank into the active bank on the next LO frame tick, so the
// phase shifters always see a complete, consistent weight set.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   bus (slave)         write port, commit_req, frame_tick, commit status
//   rd_addr, rd_data    shadow readback (only with BF_WEIGHT_READBACK_EN)
//   w_cos_1_o .. w_sin_2_o  active weights, channel i at [i*W_W +: W_W]
//
// Optional feature macro: BF_WEIGHT_READBACK_EN (registered shadow readback).
//
// Bank indexing: the write address {beam, sin, ch} is used directly as the
// bank index, so entries 0..N_CH-1 are cos1, then sin1, cos2, sin2.
// -----------------------------------------------------------------------------
module bf_weight_ctrl #(
  parameter int N_CH    = 8,
  parameter int CH_AW   = 3,
  parameter int W_W     = 5,
  parameter int TIMEOUT = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  bf_weight_ctrl_if.slave       bus,
`ifdef BF_WEIGHT_READBACK_EN
  input  logic [CH_AW+1:0]      rd_addr,
  output logic [W_W-1:0]        rd_data,
`endif
  output logic [N_CH*W_W-1:0]   w_cos_1_o,
  output logic [N_CH*W_W-1:0]   w_sin_1_o,
  output logic [N_CH*W_W-1:0]   w_cos_2_o,
  output logic [N_CH*W_W-1:0]   w_sin_2_o
);

  localparam int N_ENT = 4 * N_CH;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_ready_q;
  logic             commit_done_q;
  logic             commit_err_q;
  logic             weights_valid_q;
  logic             swap_s;
  logic             timeout_s;
  logic             wr_fire_s;

  logic [W_W-1:0]   shadow_q [N_ENT];
  logic [W_W-1:0]   active_q [N_ENT];

  // wr_ready_q is high exactly when the FSM is in IDLE
  assign wr_fire_s = bus.wr_valid & wr_ready_q;

  // Commit FSM next state: frame_tick has priority over the timeout
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    swap_s    = 1'b0;
    timeout_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        // a frame_tick in this same cycle is deliberately ignored
        if (bus.commit_req) begin
          state_d = ST_PENDING;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PENDING: begin
        cnt_d = cnt_q + CNT_ONE;
        if (bus.frame_tick) begin
          swap_s  = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_s = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_PENDING;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // FSM state, timeout counter and registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= {CNT_W{1'b0}};
      wr_ready_q      <= 1'b1;
      commit_done_q   <= 1'b0;
      commit_err_q    <= 1'b0;
      weights_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      wr_ready_q      <= (state_d == ST_IDLE);
      commit_done_q   <= (state_d == ST_DONE);
      commit_err_q    <= timeout_s;
      weights_valid_q <= weights_valid_q | swap_s;
    end
  end

  // Shadow bank: single-entry host writes
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_ENT; i++) begin
        shadow_q[i] <= {W_W{1'b0}};
      end
    end else if (wr_fire_s) begin
      shadow_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Active bank: whole-bank copy from shadow on a committed frame tick
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_ENT; i++) begin
        active_q[i] <= {W_W{1'b0}};
      end
    end else if (swap_s) begin
      for (int i = 0; i < N_ENT; i++) begin
        active_q[i] <= shadow_q[i];
      end
    end
  end

`ifdef BF_WEIGHT_READBACK_EN
  logic [W_W-1:0] rd_data_q;

  // Registered shadow readback; a same-cycle write shows up one read later
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q <= {W_W{1'b0}};
    end else begin
      rd_data_q <= shadow_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;
`endif

  assign bus.wr_ready      = wr_ready_q;
  assign bus.commit_done   = commit_done_q;
  assign bus.commit_err    = commit_err_q;
  assign bus.weights_valid = weights_valid_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign w_cos_1_o[g*W_W +: W_W] = active_q[g];
    assign w_sin_1_o[g*W_W +: W_W] = active_q[N_CH + g];
    assign w_cos_2_o[g*W_W +: W_W] = active_q[2*N_CH + g];
    assign w_sin_2_o[g*W_W +: W_W] = active_q[3*N_CH + g];
  end

endmodule

// File: doc/bf_weight_ctrl.md
Name: bf_weight_ctrl

Overview:
- Configuration controller for the 8-channel, 2-beam beamformer weight inputs (w_cos_1, w_sin_1, w_cos_2, w_sin_2).
- Host writes individual 5-bit weights into a shadow bank over a valid/ready port.
- A commit request swaps shadow into the active bank atomically at the next LO frame boundary, so the phase shifters never see a half-updated weight set.
- Sits between host/register interface and the beamformer top.

Parameters:
- N_CH, 8, number of antenna channels (power of two).
- CH_AW, 3, channel address width, log2(N_CH).
- W_W, 5, weight width in bits.
- TIMEOUT, 16, maximum cycles to wait for frame_tick after a commit request.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- wr_valid  input  1  host write request
- wr_ready  output  1  controller can accept a write
- wr_addr  input  CH_AW+2  [CH_AW-1:0] channel; [CH_AW] 0=cos/1=sin; [CH_AW+1] 0=beam1/1=beam2
- wr_data  input  W_W  weight value
- commit_req  input  1  single-cycle pulse: request shadow->active swap
- frame_tick  input  1  asserted the cycle the LO phase counter equals 3 (wraps next cycle)
- commit_done  output  1  one-cycle pulse: swap completed
- commit_err  output  1  one-cycle pulse: commit aborted on timeout
- weights_valid  output  1  high after the first successful commit
- w_cos_1_o, w_sin_1_o, w_cos_2_o, w_sin_2_o  output  N_CH*W_W each  active weights; channel i at [i*W_W +: W_W]

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset values:
  - shadow and active banks all zero; all weight outputs 0
  - wr_ready=1; commit_done=0; commit_err=0; weights_valid=0
  - state IDLE; timeout counter 0
  - Reset mid-operation discards any pending commit and any shadow contents.
- Storage: shadow bank of 4*N_CH registers and active bank of 4*N_CH registers. Outputs are driven directly from active registers; no combinational path from wr_* to outputs.
- Write handshake:
  - Accepted on a cycle with wr_valid && wr_ready.
  - The addressed shadow entry updates at that clock edge.
  - Unaccepted writes must be held by the host.
- FSM states:
  - IDLE:
    - wr_ready=1.
    - commit_req -> PENDING, counter cleared.
    - A write accepted in the same cycle as commit_req is included in the commit.
  - PENDING:
    - wr_ready=0; counter increments each cycle.
    - frame_tick=1 -> active <= shadow at this edge (visible next cycle), -> DONE.
    - Else counter==TIMEOUT-1 -> commit_err=1 next cycle, active unchanged, -> IDLE.
  - DONE:
    - Lasts exactly one cycle; commit_done=1; wr_ready=0; weights_valid set to 1 (sticky until reset).
    - -> IDLE.
- Boundary conditions:
  - commit_req and frame_tick in the same IDLE cycle: go to PENDING and wait for the next frame_tick; no same-cycle swap.
  - commit_req while in PENDING or DONE: ignored; no queuing.
  - frame_tick on the same cycle as the timeout count: frame_tick wins, commit succeeds.
  - Latency from frame_tick to new weights visible on outputs is 1 cycle. Because frame_tick is the phase-3 cycle, the swap lands exactly at LO phase 0.
  - Back-to-back commits: the second commit_req is accepted from the first IDLE cycle after DONE.

Optional Feature:
- Macro BF_WEIGHT_READBACK_EN.
- When defined:
  - Adds input rd_addr (CH_AW+2 bits, same encoding as wr_addr) and output rd_data (W_W bits).
  - rd_data is registered: it returns the shadow entry one cycle after rd_addr is presented, reset value 0.
  - A same-cycle write to the same address returns the old value.
- When undefined: both ports and the read mux are absent, and write-only behaviour is unchanged.

Test Plan:
- Reset, then write ch3 beam1 cos=5'h0B with no commit -> w_cos_1_o[19:15] stays 0, weights_valid=0.
- Same write, commit_req, frame_tick 3 cycles later -> w_cos_1_o[19:15]=0x0B one cycle after tick; commit_done pulses once; weights_valid=1; wr_ready=0 from the cycle after commit_req until after DONE.
- commit_req with frame_tick held low 16 cycles -> commit_err pulses on cycle 17; outputs unchanged; wr_ready returns to 1.
- wr_valid held during PENDING -> write not accepted until IDLE. Then it lands in shadow only: w_sin_2_o unchanged until a second commit.
- commit_req coincident with frame_tick -> no swap on that tick; swap on the following tick (4 cycles later).
- Assert reset while in PENDING with modified shadow -> all outputs 0, state IDLE, and a later commit yields all-zero weights.
